// File: rtl/game_flow_pkg.sv
// Shared types and constants for the game session sequencer.
package game_flow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_RESULT    = 3'd4
    } state_t;

    localparam logic [1:0] SCR_MENU      = 2'd0;
    localparam logic [1:0] SCR_COUNTDOWN = 2'd1;
    localparam logic [1:0] SCR_PLAY      = 2'd2;
    localparam logic [1:0] SCR_RESULT    = 2'd3;

    localparam int ELAPSED_MAX = 999;

endpackage

// File: rtl/game_flow_ctrl_tick.sv
// game_tick_gen: free-running 1 s tick divider with synchronous clear and freeze.
module game_tick_gen #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = enable && w_last;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Session sequencer: IDLE -> COUNTDOWN -> PLAY <-> PAUSE -> RESULT -> IDLE, all outputs registered.
module game_flow_ctrl
    import game_flow_pkg::*;
#(
    parameter int TICK_CYCLES   = 100_000_000,
    parameter int COUNTDOWN_S   = 3,
    parameter int RESULT_HOLD_S = 2,
    parameter int ELAPSED_MAX   = game_flow_pkg::ELAPSED_MAX
) (
    input  logic       clock_100mhz,
    input  logic       reset,
    input  logic       start_pulse,
    input  logic       pause_pulse,
    input  logic       confirm_pulse,
    input  logic       abort_req,
    input  logic       is_collision,
    input  logic       toggle_game_clear_screen,
    output logic       game_active,
    output logic       paused,
    output logic [1:0] screen_select,
    output logic [3:0] countdown_digit,
    output logic       won,
    output logic [9:0] elapsed_sec,
    output logic       return_to_menu
);

    localparam int HW = (RESULT_HOLD_S > 1) ? $clog2(RESULT_HOLD_S + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESULT_HOLD_S - 1);
    localparam logic [9:0]    EMAX      = 10'(ELAPSED_MAX);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v >= EMAX) ? EMAX : v + 10'd1;
    endfunction

    state_t        r_state, w_next;
    logic          r_active, r_paused, r_won, r_rtm;
    logic [1:0]    r_scr;
    logic [3:0]    r_digit;
    logic [9:0]    r_elapsed;
    logic [HW-1:0] r_hold;

    logic          w_tick, w_tick_clear, w_tick_en;
    logic          w_rtm, w_abort_exit, w_won;
    logic [1:0]    w_scr;
    logic [3:0]    w_digit;
    logic [9:0]    w_elapsed;
    logic [HW-1:0] w_hold;

    game_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk    (clock_100mhz),
        .reset  (reset),
        .clear  (w_tick_clear),
        .enable (w_tick_en),
        .tick   (w_tick)
    );

    always_ff @(posedge clock_100mhz) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_rtm        = 1'b0;
        w_abort_exit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_pulse) w_next = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                if (abort_req) begin
                    w_next = ST_IDLE; w_rtm = 1'b1; w_abort_exit = 1'b1;
                end else if (w_tick && r_digit == 4'd1) begin
                    w_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (abort_req) begin
                    w_next = ST_IDLE; w_rtm = 1'b1; w_abort_exit = 1'b1;
                end else if (is_collision || toggle_game_clear_screen) begin
                    w_next = ST_RESULT;
                end else if (pause_pulse) begin
                    w_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (abort_req) begin
                    w_next = ST_IDLE; w_rtm = 1'b1; w_abort_exit = 1'b1;
                end else if (pause_pulse) begin
                    w_next = ST_PLAY;
                end
            end
            ST_RESULT: begin
                // Abort here is just another way of acknowledging the result.
                if (confirm_pulse || abort_req || (w_tick && r_hold == HOLD_LAST)) begin
                    w_next = ST_IDLE; w_rtm = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tick_en    = (r_state == ST_COUNTDOWN) || (r_state == ST_PLAY) || (r_state == ST_RESULT);
        w_tick_clear = (r_state == ST_IDLE) ||
                       (w_next != r_state && (w_next == ST_COUNTDOWN || w_next == ST_RESULT ||
                                              (w_next == ST_PLAY && r_state == ST_COUNTDOWN)));

        case (w_next)
            ST_COUNTDOWN:     w_scr = SCR_COUNTDOWN;
            ST_PLAY, ST_PAUSE: w_scr = SCR_PLAY;
            ST_RESULT:        w_scr = SCR_RESULT;
            default:          w_scr = SCR_MENU;
        endcase

        w_digit = 4'd0;
        if (w_next == ST_COUNTDOWN) begin
            if (r_state == ST_IDLE) w_digit = 4'(COUNTDOWN_S);
            else                    w_digit = w_tick ? r_digit - 4'd1 : r_digit;
        end

        w_won = r_won;
        if ((r_state == ST_IDLE && start_pulse) || w_abort_exit) w_won = 1'b0;
        else if (r_state == ST_PLAY && w_next == ST_RESULT)      w_won = ~is_collision;

        w_elapsed = r_elapsed;
        if ((r_state == ST_IDLE && start_pulse) || w_abort_exit) w_elapsed = 10'd0;
        else if (r_state == ST_PLAY && w_tick)                   w_elapsed = sat_inc(r_elapsed);

        w_hold = '0;
        if (r_state == ST_RESULT && w_next == ST_RESULT) w_hold = w_tick ? r_hold + 1'b1 : r_hold;
    end

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            r_active  <= 1'b0;
            r_paused  <= 1'b0;
            r_won     <= 1'b0;
            r_rtm     <= 1'b0;
            r_scr     <= SCR_MENU;
            r_digit   <= 4'd0;
            r_elapsed <= 10'd0;
            r_hold    <= '0;
        end else begin
            r_active  <= (w_next == ST_PLAY);
            r_paused  <= (w_next == ST_PAUSE);
            r_won     <= w_won;
            r_rtm     <= w_rtm;
            r_scr     <= w_scr;
            r_digit   <= w_digit;
            r_elapsed <= w_elapsed;
            r_hold    <= w_hold;
        end
    end

    assign game_active     = r_active;
    assign paused          = r_paused;
    assign won             = r_won;
    assign return_to_menu  = r_rtm;
    assign screen_select   = r_scr;
    assign countdown_digit = r_digit;
    assign elapsed_sec     = r_elapsed;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with TICK_CYCLES=10, COUNTDOWN_S=3, RESULT_HOLD_S=2.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset, start_pulse, pause_pulse, confirm_pulse, abort_req;
    logic       is_collision, toggle_game_clear_screen;
    logic       game_active, paused, won, return_to_menu;
    logic [1:0] screen_select;
    logic [3:0] countdown_digit;
    logic [9:0] elapsed_sec;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .TICK_CYCLES   (10),
        .COUNTDOWN_S   (3),
        .RESULT_HOLD_S (2),
        .ELAPSED_MAX   (999)
    ) dut (
        .clock_100mhz             (clk),
        .reset                    (reset),
        .start_pulse              (start_pulse),
        .pause_pulse              (pause_pulse),
        .confirm_pulse            (confirm_pulse),
        .abort_req                (abort_req),
        .is_collision             (is_collision),
        .toggle_game_clear_screen (toggle_game_clear_screen),
        .game_active              (game_active),
        .paused                   (paused),
        .screen_select            (screen_select),
        .countdown_digit          (countdown_digit),
        .won                      (won),
        .elapsed_sec              (elapsed_sec),
        .return_to_menu           (return_to_menu)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_active"},  int'(game_active), 0);
        check({tag, "_paused"},  int'(paused), 0);
        check({tag, "_screen"},  int'(screen_select), 0);
        check({tag, "_digit"},   int'(countdown_digit), 0);
        check({tag, "_elapsed"}, int'(elapsed_sec), 0);
        check({tag, "_won"},     int'(won), 0);
        check({tag, "_rtm"},     int'(return_to_menu), 0);
    endtask

    // Start from IDLE and run the 3-tick countdown; returns on the first PLAY cycle.
    task automatic start_to_play();
        start_pulse = 1'b1; step(1); start_pulse = 1'b0;
        step(30);
        check("enter_play_active", int'(game_active), 1);
    endtask

    initial begin
        reset = 1'b1; start_pulse = 1'b0; pause_pulse = 1'b0; confirm_pulse = 1'b0;
        abort_req = 1'b0; is_collision = 1'b0; toggle_game_clear_screen = 1'b0;
        step(2);
        reset = 1'b0;
        check_idle("reset");

        // Countdown; cycle 0 is the start_pulse cycle.
        start_pulse = 1'b1; step(1); start_pulse = 1'b0;            // cycle 1
        check("cd_digit3", int'(countdown_digit), 3);
        check("cd_screen", int'(screen_select), 1);
        step(10);                                                   // cycle 11
        check("cd_digit2", int'(countdown_digit), 2);
        step(10);                                                   // cycle 21
        check("cd_digit1", int'(countdown_digit), 1);
        check("cd_not_active", int'(game_active), 0);
        step(10);                                                   // cycle 31
        check("play_active", int'(game_active), 1);
        check("play_screen", int'(screen_select), 2);
        check("play_digit0", int'(countdown_digit), 0);
        check("play_elapsed0", int'(elapsed_sec), 0);
        step(10);                                                   // cycle 41
        check("elapsed1", int'(elapsed_sec), 1);

        // start_pulse in PLAY must not disturb anything, including tick phase.
        step(4);                                                    // cycle 45
        start_pulse = 1'b1; step(1); start_pulse = 1'b0;            // cycle 46
        check("ign_start_active", int'(game_active), 1);
        check("ign_start_screen", int'(screen_select), 2);
        check("ign_start_digit", int'(countdown_digit), 0);
        step(4);                                                    // cycle 50
        check("ign_start_el_before", int'(elapsed_sec), 1);
        step(1);                                                    // cycle 51
        check("ign_start_el_after", int'(elapsed_sec), 2);

        // Pause after 25 PLAY cycles (31..55); tick count 5 -> 6 on that edge.
        step(5);                                                    // cycle 56
        check("pre_pause_elapsed", int'(elapsed_sec), 2);
        pause_pulse = 1'b1; step(1); pause_pulse = 1'b0;            // cycle 57
        check("pause_active", int'(game_active), 0);
        check("pause_paused", int'(paused), 1);
        check("pause_screen", int'(screen_select), 2);
        is_collision = 1'b1; step(1); is_collision = 1'b0;          // cycle 58
        check("pause_ign_coll", int'(paused), 1);
        check("pause_ign_coll_scr", int'(screen_select), 2);
        step(48);                                                   // cycle 106
        check("pause_hold_elapsed", int'(elapsed_sec), 2);
        step(1);                                                    // cycle 107
        pause_pulse = 1'b1; step(1); pause_pulse = 1'b0;            // cycle 108
        check("resume_active", int'(game_active), 1);
        check("resume_paused", int'(paused), 0);
        step(3);                                                    // cycle 111
        check("resume_el_before", int'(elapsed_sec), 2);
        step(1);                                                    // cycle 112
        check("resume_el_after", int'(elapsed_sec), 3);

        // Abort from PAUSE.
        pause_pulse = 1'b1; step(1); pause_pulse = 1'b0;
        check("abort_pre_paused", int'(paused), 1);
        abort_req = 1'b1; step(1); abort_req = 1'b0;
        check("abort_rtm", int'(return_to_menu), 1);
        check("abort_screen", int'(screen_select), 0);
        step(1);
        check_idle("after_abort");

        // Collision and clear together: collision wins.
        start_to_play();
        is_collision = 1'b1; toggle_game_clear_screen = 1'b1;
        step(1);
        is_collision = 1'b0; toggle_game_clear_screen = 1'b0;       // RESULT entry, cycle 0
        check("coll_won", int'(won), 0);
        check("coll_screen", int'(screen_select), 3);
        check("coll_active", int'(game_active), 0);
        step(19);
        check("hold_rtm_early", int'(return_to_menu), 0);
        check("hold_screen", int'(screen_select), 3);
        step(1);                                                    // cycle 20
        check("hold_rtm", int'(return_to_menu), 1);
        check("hold_exit_screen", int'(screen_select), 0);
        step(1);
        check("hold_rtm_once", int'(return_to_menu), 0);

        // Clear only, then confirm at RESULT cycle 3.
        start_to_play();
        toggle_game_clear_screen = 1'b1; step(1); toggle_game_clear_screen = 1'b0;
        check("clear_won", int'(won), 1);
        check("clear_screen", int'(screen_select), 3);
        step(3);
        confirm_pulse = 1'b1; step(1); confirm_pulse = 1'b0;        // cycle 4
        check("confirm_rtm", int'(return_to_menu), 1);
        check("confirm_screen", int'(screen_select), 0);
        step(1);
        check("confirm_rtm_once", int'(return_to_menu), 0);

        // Start and abort together in IDLE: start wins.
        start_pulse = 1'b1; abort_req = 1'b1; step(1);
        start_pulse = 1'b0; abort_req = 1'b0;
        check("start_abort_digit", int'(countdown_digit), 3);
        check("start_abort_rtm", int'(return_to_menu), 0);
        step(10);
        check("midcd_digit2", int'(countdown_digit), 2);

        // Reset in the middle of COUNTDOWN.
        reset = 1'b1; step(1); reset = 1'b0;
        check("rst_digit", int'(countdown_digit), 0);
        check("rst_screen", int'(screen_select), 0);
        check("rst_rtm", int'(return_to_menu), 0);
        step(1);
        check("rst_rtm_after", int'(return_to_menu), 0);
        start_pulse = 1'b1; step(1); start_pulse = 1'b0;
        check("restart_digit", int'(countdown_digit), 3);
        check("restart_screen", int'(screen_select), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level session sequencer for the game datapath: IDLE → COUNTDOWN → PLAY ⇄ PAUSE → RESULT → IDLE.
- Drives `game_active` to the player, stage and logic blocks.
- Selects which screen layer the OLED path shows.
- Consumes the collision and game-clear results from the logic block, and issues the one-cycle `return_to_menu` pulse to the menu.

Parameters:
- TICK_CYCLES, 100_000_000, clock cycles per 1 s game tick; benches use 10.
- COUNTDOWN_S, 3, countdown length in ticks (1..9).
- RESULT_HOLD_S, 2, ticks the result screen is held before auto-return (≥1).
- ELAPSED_MAX, 999, saturation value of the play timer.

Ports:
- clock_100mhz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_pulse  in  1  one-cycle start request from the menu (debounced upstream).
- pause_pulse  in  1  one-cycle pause/resume toggle.
- confirm_pulse  in  1  one-cycle btnC press; skips the result hold.
- abort_req  in  1  level; forces return to menu.
- is_collision  in  1  level from the logic block.
- toggle_game_clear_screen  in  1  level from the logic block.
- game_active  out  1  high only in PLAY.
- paused  out  1  high in PAUSE.
- screen_select  out  2  0 = menu, 1 = countdown, 2 = play, 3 = result.
- countdown_digit  out  4  remaining countdown value; 0 outside COUNTDOWN.
- won  out  1  result flag: 1 = game clear, 0 = collision; valid in RESULT.
- elapsed_sec  out  10  play seconds, saturating.
- return_to_menu  out  1  one-cycle pulse.

Behaviour:
- All outputs are registered. Each takes its new value on the clock edge after the causing event (latency 1).
- Reset values:
  - State is IDLE.
  - game_active, paused, won and return_to_menu are 0.
  - screen_select is 0, countdown_digit is 0, elapsed_sec is 0.
  - Tick counter is 0.
  - Reset asserted in any state, mid-operation included, restores these on the next edge. No `return_to_menu` pulse is emitted on reset.
- Tick counter:
  - Counts 0..TICK_CYCLES-1. `tick` is asserted in the cycle the count equals TICK_CYCLES-1, and the count then wraps to 0.
  - Cleared on entry to COUNTDOWN, PLAY (from COUNTDOWN) and RESULT.
  - Held at 0 in IDLE. Frozen (not cleared) in PAUSE.
- IDLE:
  - start_pulse → COUNTDOWN with countdown_digit = COUNTDOWN_S and screen_select = 1. elapsed_sec and won are cleared.
  - pause_pulse and confirm_pulse are ignored.
- COUNTDOWN:
  - On tick, countdown_digit decrements.
  - Tick while the digit equals 1 → PLAY, with digit = 0, game_active = 1 and screen_select = 2.
  - pause_pulse is ignored.
- PLAY:
  - Each tick increments elapsed_sec, saturating at ELAPSED_MAX.
  - is_collision → RESULT with won = 0.
  - Otherwise toggle_game_clear_screen → RESULT with won = 1.
  - Otherwise pause_pulse → PAUSE.
  - Priority is collision > clear > pause when these coincide.
  - On any exit, game_active drops on the same edge.
- PAUSE:
  - game_active = 0, paused = 1, screen_select stays 2.
  - is_collision and the clear input are ignored.
  - pause_pulse → PLAY, resuming the frozen tick count.
- RESULT:
  - screen_select = 3.
  - Exits on the RESULT_HOLD_S-th tick, or on confirm_pulse in any cycle after entry.
  - Exit: next state is IDLE, with return_to_menu = 1 for exactly one cycle and screen_select = 0.
- abort_req in COUNTDOWN, PLAY or PAUSE:
  - → IDLE with a single return_to_menu pulse.
  - abort_req has priority over all other inputs in those states.
  - In RESULT it behaves as confirm.
- start_pulse outside IDLE is ignored.
- Simultaneous start_pulse and abort_req in IDLE: start wins.
- Widths: countdown_digit is 4 bits. The tick counter is $clog2(TICK_CYCLES) bits. Hold counter comparisons use equality, never overflow.

Decomposition:
- Package game_flow_pkg holds:
  - State encoding: IDLE = 0, COUNTDOWN = 1, PLAY = 2, PAUSE = 3, RESULT = 4; 3-bit.
  - Screen-select constants.
  - ELAPSED_MAX.
- Sub-module game_tick_gen (parameter TICK_CYCLES; inputs clear and enable; output tick) implements the tick counter.
- The FSM, digit counter, elapsed timer and hold counter live in game_flow_ctrl.

Test Plan (TICK_CYCLES = 10, COUNTDOWN_S = 3, RESULT_HOLD_S = 2):
1. Reset, then start_pulse at cycle 0 → countdown_digit is 3 at cycle 1, 2 at cycle 11 and 1 at cycle 21. At cycle 31 the block is in PLAY with game_active = 1 and screen_select = 2.
2. Pause and resume:
   - Stimulus: in PLAY run 25 cycles, then pause_pulse; hold 50 cycles; pause_pulse again.
   - Required: elapsed_sec = 2. After the first pause_pulse, game_active = 0 and paused = 1 next cycle. elapsed_sec stays 2 through the hold. After resume, elapsed_sec = 3 after 5 further cycles.
3. is_collision and toggle_game_clear_screen high in the same PLAY cycle → RESULT with won = 0, screen_select = 3 and game_active = 0 on the next edge.
4. RESULT exit:
   - With no input, return_to_menu is high for exactly 1 cycle, 20 cycles after RESULT entry, and state is IDLE.
   - With confirm_pulse at RESULT cycle 3, the pulse occurs at cycle 4.
5. Ignored inputs and abort:
   - start_pulse during PLAY leaves state, elapsed_sec and the tick phase unchanged.
   - abort_req in PAUSE gives one return_to_menu pulse, then IDLE with all outputs at reset values.
6. reset asserted mid-COUNTDOWN (digit 2) → next edge: IDLE, countdown_digit = 0, no return_to_menu pulse. A following start_pulse restarts the countdown at digit 3.
